aes_round_ctrl: RTL

Iterative AES-128 encryption sequencer. Runs one full cipher round per clock over a single 128-bit round datapath: `subbytes`, ShiftRows, MixColumns and AddRoundKey. Expands the round key on the fly. Sits between the host interface and the substitution datapath, and is the only block that drives `subbytes` in the encryption path.

---
 rtl/aes_round_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer, one cipher round
// per clock, with the round key expanded on the fly.
// Optional feature macro: AES_ROUND_CTRL_ABORT_EN (adds the abort input).

// Single AES S-box: GF(2^8) inverse via x^254, then the affine transform.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for x^254 (maps 0 to 0 as required)
  assign x2   = gmul(din, din);
  assign x3   = gmul(x2, din);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);

  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// SubBytes over the full 128-bit state: 16 parallel S-boxes.
module aes_subbytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (.din(din[8*g +: 8]), .dout(dout[8*g +: 8]));
  end

endmodule

// Round sequencer top level.
module aes_round_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       fsm;
  logic [127:0] st, rk, sb, sr, mc, nrk, rnd_out;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [31:0]  rot, sw, w0n, w1n, w2n, w3n;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  aes_subbytes u_subbytes (.din(st), .dout(sb));

  // Key schedule: SubWord(RotWord(w3)) on its own four S-boxes
  assign rot = {rk[23:0], rk[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_ksbox (.din(rot[8*g +: 8]), .dout(sw[8*g +: 8]));
  end

  assign w0n = rk[127:96] ^ sw ^ {rcon, 24'h0};
  assign w1n = rk[95:64] ^ w0n;
  assign w2n = rk[63:32] ^ w1n;
  assign w3n = rk[31:0] ^ w2n;
  assign nrk = {w0n, w1n, w2n, w3n};

  // ShiftRows and MixColumns on the substituted state
  always_comb begin
    sr = '0;
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
    end
  end

  // Final round skips MixColumns
  assign rnd_out = (cnt == 4'(ROUNDS)) ? (sr ^ nrk) : (mc ^ nrk);

  // Control FSM with datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      st         <= '0;
      rk         <= '0;
      cnt        <= '0;
      rcon       <= 8'h01;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            st   <= plaintext ^ key;
            rk   <= key;
            cnt  <= 4'd1;
            rcon <= 8'h01;
            fsm  <= RUN;
            busy <= 1'b1;
          end else begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end
        end
        RUN: begin
          // abort, when built in, takes priority over the round update
`ifdef AES_ROUND_CTRL_ABORT_EN
          if (abort) begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end else
`endif
          begin
            st   <= rnd_out;
            rk   <= nrk;
            cnt  <= cnt + 4'd1;
            rcon <= xtime(rcon);
            if (cnt == 4'(ROUNDS)) begin
              ciphertext <= rnd_out;
              fsm        <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
